// File: rtl/sweep_pkg.sv
// Shared types and defaults for the up/down sweep sequencer.
//   sweep_state_e : sequencer states
//   LW_DEF/PW_DEF : default lap-count and prescaler widths
package sweep_pkg;

    localparam int LW_DEF = 8;
    localparam int PW_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_UP,
        ST_DOWN,
        ST_DONE
    } sweep_state_e;

endpackage

// File: rtl/updown_sweep_ctrl_if.sv
// Control/status bundle between a register block (master) and the sweep
// sequencer (slave).
//   start, abort          : request strobes
//   cfg_up_laps/down_laps : lap counts, sampled when a sweep starts
//   cfg_presc             : enable period minus 1, sampled on start
//   busy, done, aborted   : sweep status
//   lap_cnt               : laps completed in the current phase
interface updown_sweep_ctrl_if #(
    parameter int LW = sweep_pkg::LW_DEF,
    parameter int PW = sweep_pkg::PW_DEF
);
    logic          start;
    logic          abort;
    logic [LW-1:0] cfg_up_laps;
    logic [LW-1:0] cfg_down_laps;
    logic [PW-1:0] cfg_presc;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [LW-1:0] lap_cnt;

    modport master (
        output start, abort, cfg_up_laps, cfg_down_laps, cfg_presc,
        input  busy, done, aborted, lap_cnt
    );

    modport slave (
        input  start, abort, cfg_up_laps, cfg_down_laps, cfg_presc,
        output busy, done, aborted, lap_cnt
    );
endinterface

// File: rtl/sweep_prescaler.sv
// Enable throttle: while run is high, tick fires once every presc+1 cycles.
//   clk, rst : clock, synchronous active-high reset
//   run      : advance the divider (held value otherwise)
//   clr      : synchronous clear to 0
//   presc    : period minus 1
//   tick     : high on the cycle the divider equals presc (only while run)
module sweep_prescaler
    import sweep_pkg::*;
#(
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          clr,
    input  logic [PW-1:0] presc,
    output logic          tick
);
    logic [PW-1:0] div_q;

    assign tick = run && (div_q == presc);

    always_ff @(posedge clk) begin
        if (rst || clr)
            div_q <= '0;
        else if (run)
            div_q <= tick ? '0 : div_q + PW'(1);
    end
endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sequencer for an N-bit up/down wrap counter: clear, count up for a number
// of laps, count down for a number of laps, then pulse done.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : control/status bundle (slave side)
//   cnt_pulse : counter terminal pulse (en && count at MAX/0 per direction)
//   cnt_clr_n : counter active-low clear
//   cnt_en    : counter enable
//   cnt_up    : counter direction, 1 = up
module updown_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int LW = LW_DEF,
    parameter int PW = PW_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    updown_sweep_ctrl_if.slave         bus,
    input  logic                       cnt_pulse,
    output logic                       cnt_clr_n,
    output logic                       cnt_en,
    output logic                       cnt_up
);
    sweep_state_e  state_q, state_d;
    logic [LW-1:0] lap_q, lap_d, lap_inc;
    logic [LW-1:0] up_laps_q, down_laps_q;
    logic [PW-1:0] presc_q;
    logic          first_q, first_d;
    logic          aborted_q, aborted_d;
    logic          latch;
    logic          tick, run, step;

    assign run     = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign step    = cnt_en && cnt_pulse;
    assign lap_inc = lap_q + LW'(1);

    sweep_prescaler #(.PW(PW)) u_presc (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .clr   (state_q == ST_CLEAR),
        .presc (presc_q),
        .tick  (tick)
    );

    // All outputs decode from registered state; start/abort only reach
    // them through a clock edge.
    assign cnt_en      = tick;
    assign cnt_clr_n   = (state_q != ST_CLEAR);
    assign cnt_up      = (state_q != ST_DOWN);
    assign bus.busy    = run || (state_q == ST_CLEAR);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.aborted = aborted_q;
    assign bus.lap_cnt = lap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lap_q       <= '0;
            first_q     <= 1'b0;
            aborted_q   <= 1'b0;
            up_laps_q   <= '0;
            down_laps_q <= '0;
            presc_q     <= '0;
        end else begin
            state_q   <= state_d;
            lap_q     <= lap_d;
            first_q   <= first_d;
            aborted_q <= aborted_d;
            if (latch) begin
                up_laps_q   <= bus.cfg_up_laps;
                down_laps_q <= bus.cfg_down_laps;
                presc_q     <= bus.cfg_presc;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        lap_d     = lap_q;
        first_d   = first_q;
        aborted_d = 1'b0;
        latch     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // abort together with start suppresses the start
                if (bus.start && !bus.abort) begin
                    latch   = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                lap_d   = '0;
                first_d = 1'b1;
                if (up_laps_q != '0)        state_d = ST_UP;
                else if (down_laps_q != '0) state_d = ST_DOWN;
                else                        state_d = ST_DONE;
            end
            ST_UP: begin
                if (step) begin
                    if (lap_inc == up_laps_q) begin
                        lap_d   = '0;
                        first_d = 1'b1;
                        state_d = (down_laps_q != '0) ? ST_DOWN : ST_DONE;
                    end else begin
                        lap_d = lap_inc;
                    end
                end
            end
            ST_DOWN: begin
                // The first enabled step is the 0->MAX wrap left over from
                // the up phase; its pulse does not close a down lap.
                if (cnt_en)
                    first_d = 1'b0;
                if (step && !first_q) begin
                    lap_d = lap_inc;
                    if (lap_inc == down_laps_q)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort in DONE still lets done pulse but reports no abort.
        if (bus.abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            aborted_d = (state_q != ST_DONE);
        end
    end
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
module tb_updown_sweep_ctrl;
    localparam int LW = 8;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst;
    logic cnt_clr_n, cnt_en, cnt_up, cnt_pulse;
    logic [3:0] cnt = 4'd0;
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    updown_sweep_ctrl_if #(.LW(LW), .PW(PW)) bus ();

    updown_sweep_ctrl #(.LW(LW), .PW(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .cnt_pulse (cnt_pulse),
        .cnt_clr_n (cnt_clr_n),
        .cnt_en    (cnt_en),
        .cnt_up    (cnt_up)
    );

    // N=4 up/down wrap counter driven by the sequencer
    assign cnt_pulse = cnt_en && (cnt_up ? (cnt == 4'd15) : (cnt == 4'd0));
    always_ff @(posedge clk) begin
        if (!cnt_clr_n)  cnt <= 4'd0;
        else if (cnt_en) cnt <= cnt_up ? cnt + 4'd1 : cnt - 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic set_cfg(input int u, input int d, input int p);
        bus.cfg_up_laps   = LW'(u);
        bus.cfg_down_laps = LW'(d);
        bus.cfg_presc     = PW'(p);
    endtask

    // Full sweep with expectations from lap arithmetic: each up lap is 16
    // enables; the down phase needs one extra enable for the 0->15 wrap.
    // Random start strobes and cfg changes are thrown at it while busy.
    task automatic run_sweep(input string tag, input int u, input int d, input int p);
        int e_exp, busy_exp, busy_n, en_n, cyc;
        e_exp    = 16 * (u + d) + ((d > 0) ? 1 : 0);
        busy_exp = 1 + e_exp * (p + 1);
        set_cfg(u, d, p);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, ".clear"}, {cnt_clr_n, bus.busy, bus.aborted, cnt_en}, 4'b0100);
        busy_n = 0; en_n = 0; cyc = 0;
        while (!bus.done && cyc < 5000) begin
            if (bus.busy) busy_n++;
            if (cnt_en)   en_n++;
            bus.start = ($urandom_range(0, 5) == 0);
            set_cfg($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk({tag, ".done_seen"}, bus.done, 1'b1);
        chk({tag, ".latency"}, cyc, busy_exp);
        chk({tag, ".busy_cycles"}, busy_n, busy_exp);
        chk({tag, ".enables"}, en_n, e_exp);
        chk({tag, ".counter"}, cnt, (d > 0) ? 15 : 0);
        chk({tag, ".done_busy_en"}, {bus.busy, cnt_en, bus.aborted}, 3'b000);
        if (d > 0) chk({tag, ".lap_final"}, bus.lap_cnt, d);
        @(negedge clk);
        chk({tag, ".done_one_cycle"}, bus.done, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_cfg(0, 0, 0);
        tick_n(3);
        chk("reset.outs", {cnt_clr_n, cnt_en, cnt_up, bus.busy, bus.done, bus.aborted}, 6'b101000);
        chk("reset.lap", bus.lap_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        run_sweep("updown", 2, 1, 0);
        run_sweep("presc", 1, 0, 2);
        run_sweep("zero", 0, 0, 0);
        run_sweep("downonly", 0, 2, 1);

        // abort on the 10th UP cycle
        set_cfg(2, 1, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        tick_n(10);
        chk("abort.in_up", {bus.busy, cnt_en, cnt_up}, 3'b111);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort.pulse", {bus.aborted, bus.done, bus.busy, cnt_en}, 4'b1000);
        chk("abort.counter", cnt, 10);
        run_sweep("after_abort", 1, 0, 0);

        // start and abort together in IDLE
        set_cfg(1, 1, 0);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("collide.idle", {bus.busy, bus.aborted, bus.done, cnt_clr_n}, 4'b0001);
        @(negedge clk);
        chk("collide.stay", {bus.busy, bus.aborted, bus.done}, 3'b000);

        // abort in the DONE cycle
        set_cfg(0, 0, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("abort_done.in_done", bus.done, 1'b1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_done.no_pulse", {bus.aborted, bus.done, bus.busy}, 3'b000);

        // reset in the middle of the down phase
        set_cfg(1, 1, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        tick_n(20);
        chk("rst_mid.in_down", {bus.busy, cnt_up, cnt_en}, 3'b101);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.outs", {cnt_clr_n, cnt_en, cnt_up, bus.busy, bus.done, bus.aborted}, 6'b101000);
        chk("rst_mid.lap", bus.lap_cnt, 0);
        tick_n(3);
        chk("rst_mid.idle", {bus.busy, bus.done}, 2'b00);

        for (int k = 0; k < 8; k++)
            run_sweep($sformatf("rand%0d", k), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
